// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register-bank write port between NREQ requesters.
// Every output is registered so the bank's enables are glitch-free.

module reg_write_arbiter_lane #(
  parameter int NREGS = 4,
  parameter int AW    = 2,
  parameter int WIDTH = 8
) (
  input  logic             req,
  input  logic             gnt,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] data,
  input  logic             sel,
  output logic             elig,
  output logic [NREGS-1:0] en,
  output logic [WIDTH-1:0] dout
);
  // A requester still seeing its grant is dropping req; not eligible yet.
  assign elig = req & ~gnt;
  assign dout = sel ? data : '0;

  // Addresses at or beyond NREGS decode to no enable: the write is dropped.
  for (genvar r = 0; r < NREGS; r++) begin : g_dec
    assign en[r] = sel & (addr == AW'(r));
  end
endmodule

module reg_write_arbiter #(
  parameter int NREQ  = 2,
  parameter int NREGS = 4,
  parameter int AW    = 2,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  nclr,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    addr,
  input  logic [NREQ*WIDTH-1:0] data,
  input  logic                  hold,
  output logic [NREQ-1:0]       gnt,
  output logic [NREGS-1:0]      wr_en,
  output logic [WIDTH-1:0]      wr_data,
  output logic                  busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]                   ptr, win, ptr_nxt;
  logic                            found;
  int                              scan_idx;
  logic [NREQ-1:0]                 elig, gnt_nxt;
  logic [NREQ-1:0][NREGS-1:0]      lane_en;
  logic [NREQ-1:0][WIDTH-1:0]      lane_data;
  logic [NREGS-1:0]                wr_en_nxt;
  logic [WIDTH-1:0]                wr_data_nxt;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    reg_write_arbiter_lane #(.NREGS(NREGS), .AW(AW), .WIDTH(WIDTH)) u_lane (
      .req  (req[i]),
      .gnt  (gnt[i]),
      .addr (addr[i*AW +: AW]),
      .data (data[i*WIDTH +: WIDTH]),
      .sel  (gnt_nxt[i]),
      .elig (elig[i]),
      .en   (lane_en[i]),
      .dout (lane_data[i])
    );
  end

  // First eligible index scanning ptr, ptr+1, ... mod NREQ; hold suppresses any winner.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = int'(ptr) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      if (!found && !hold && elig[scan_idx]) begin
        found = 1'b1;
        win   = PW'(scan_idx);
      end
    end
  end

  always_comb begin
    ptr_nxt = (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
    for (int i = 0; i < NREQ; i++)
      gnt_nxt[i] = found && (win == PW'(i));
  end

  // Non-selected lanes contribute zero, so OR-reduction is a one-hot mux.
  always_comb begin
    wr_en_nxt   = '0;
    wr_data_nxt = '0;
    for (int i = 0; i < NREQ; i++) begin
      wr_en_nxt   = wr_en_nxt | lane_en[i];
      wr_data_nxt = wr_data_nxt | lane_data[i];
    end
  end

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      gnt     <= '0;
      wr_en   <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      ptr     <= '0;
    end else begin
      gnt   <= gnt_nxt;
      wr_en <= wr_en_nxt;
      busy  <= |(req & ~gnt_nxt);
      if (found) begin
        wr_data <= wr_data_nxt;
        ptr     <= ptr_nxt;
      end
    end
  end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a small register-bank model on wr_en/wr_data.

module tb_reg_write_arbiter;
  localparam int NREQ = 2, NREGS = 4, AW = 2, WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  nclr;
  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    addr;
  logic [NREQ*WIDTH-1:0] data;
  logic                  hold;
  logic [NREQ-1:0]       gnt, gnt3;
  logic [NREGS-1:0]      wr_en;
  logic [2:0]            wr_en3;
  logic [WIDTH-1:0]      wr_data, wr_data3;
  logic                  busy, busy3;
  logic [NREGS-1:0][WIDTH-1:0] regs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_write_arbiter #(.NREQ(NREQ), .NREGS(NREGS), .AW(AW), .WIDTH(WIDTH)) u_dut (
    .clk(clk), .nclr(nclr), .req(req), .addr(addr), .data(data), .hold(hold),
    .gnt(gnt), .wr_en(wr_en), .wr_data(wr_data), .busy(busy)
  );

  // Second instance with a 3-entry bank to exercise out-of-range addresses.
  reg_write_arbiter #(.NREQ(NREQ), .NREGS(3), .AW(AW), .WIDTH(WIDTH)) u_dut3 (
    .clk(clk), .nclr(nclr), .req(req), .addr(addr), .data(data), .hold(hold),
    .gnt(gnt3), .wr_en(wr_en3), .wr_data(wr_data3), .busy(busy3)
  );

  // Register bank model: each entry loads wr_data when its enable is high.
  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) regs <= '0;
    else
      for (int r = 0; r < NREGS; r++)
        if (wr_en[r]) regs[r] <= wr_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req  = '0; addr = '0; data = '0; hold = 1'b0;
    nclr = 1'b0;
    tick();
    nclr = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    nclr = 1'b0; req = 2'b11; addr = '0; data = '0; hold = 1'b0;
    #100;
    checks++; if (gnt !== 2'b00)     begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
    checks++; if (wr_en !== 4'b0000) begin errors++; $display("FAIL reset_wr_en: got %b expected 0000", wr_en); end
    checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h expected 00", wr_data); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(negedge clk);
    nclr = 1'b1;
    tick();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL reset_first_grant: got %b expected 01", gnt); end
    req = 2'b00;
    tick();
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_idle: got %b expected 00", gnt); end
  endtask

  task automatic test_single();
    do_reset();
    req = 2'b01; addr = {2'd0, 2'd2}; data = {8'h00, 8'h12};
    tick();
    checks++; if (gnt !== 2'b01)     begin errors++; $display("FAIL single_gnt: got %b expected 01", gnt); end
    checks++; if (wr_en !== 4'b0100) begin errors++; $display("FAIL single_wr_en: got %b expected 0100", wr_en); end
    checks++; if (wr_data !== 8'h12) begin errors++; $display("FAIL single_wr_data: got %h expected 12", wr_data); end
    req = 2'b00;
    tick();
    checks++; if (regs[2] !== 8'h12) begin errors++; $display("FAIL single_reg2: got %h expected 12", regs[2]); end
    checks++; if ({regs[3], regs[1], regs[0]} !== 24'h0)
      begin errors++; $display("FAIL single_other_regs: got %h expected 000000", {regs[3], regs[1], regs[0]}); end
    checks++; if (wr_en !== 4'b0000) begin errors++; $display("FAIL single_wr_en_off: got %b expected 0000", wr_en); end
  endtask

  task automatic test_contention();
    do_reset();
    req = 2'b11; addr = {2'd1, 2'd1}; data = {8'h56, 8'h34};
    tick();
    checks++; if (gnt !== 2'b01)     begin errors++; $display("FAIL cont_gnt0: got %b expected 01", gnt); end
    checks++; if (wr_data !== 8'h34) begin errors++; $display("FAIL cont_data0: got %h expected 34", wr_data); end
    checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL cont_busy: got %b expected 1", busy); end
    req = 2'b10;
    tick();
    checks++; if (gnt !== 2'b10)     begin errors++; $display("FAIL cont_gnt1: got %b expected 10", gnt); end
    checks++; if (wr_en !== 4'b0010) begin errors++; $display("FAIL cont_wr_en1: got %b expected 0010", wr_en); end
    checks++; if (wr_data !== 8'h56) begin errors++; $display("FAIL cont_data1: got %h expected 56", wr_data); end
    checks++; if (regs[1] !== 8'h34) begin errors++; $display("FAIL cont_reg1_mid: got %h expected 34", regs[1]); end
    req = 2'b00;
    tick();
    checks++; if (regs[1] !== 8'h56) begin errors++; $display("FAIL cont_reg1_final: got %h expected 56", regs[1]); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL cont_busy_idle: got %b expected 0", busy); end
  endtask

  task automatic test_fairness();
    logic [1:0] exp;
    do_reset();
    req = 2'b11; addr = {2'd3, 2'd0}; data = {8'hB1, 8'hA0};
    for (int i = 0; i < 8; i++) begin
      tick();
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (gnt !== exp) begin errors++; $display("FAIL fair_gnt[%0d]: got %b expected %b", i, gnt, exp); end
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 2'b01; addr = {2'd0, 2'd3}; data = {8'h00, 8'h9C};
    tick();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL b2b_first: got %b expected 01", gnt); end
    tick();
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL b2b_gap: got %b expected 00", gnt); end
    tick();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL b2b_regrant: got %b expected 01", gnt); end
    req = 2'b00;
    tick();
  endtask

  task automatic test_hold();
    do_reset();
    hold = 1'b1; req = 2'b11; addr = {2'd2, 2'd1}; data = {8'h22, 8'h11};
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (gnt !== 2'b00 || wr_en !== 4'b0000)
        begin errors++; $display("FAIL hold_block[%0d]: got gnt=%b wr_en=%b expected 00/0000", i, gnt, wr_en); end
    end
    hold = 1'b0;
    tick();
    checks++; if (gnt !== 2'b01)     begin errors++; $display("FAIL hold_release_gnt: got %b expected 01", gnt); end
    checks++; if (wr_en !== 4'b0010) begin errors++; $display("FAIL hold_release_wr_en: got %b expected 0010", wr_en); end
    req = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    req = 2'b01; addr = {2'd0, 2'd0}; data = {8'h00, 8'hAA};
    tick();
    checks++; if (wr_en !== 4'b0001) begin errors++; $display("FAIL midrst_pre: got %b expected 0001", wr_en); end
    nclr = 1'b0;
    #1;
    checks++; if (wr_en !== 4'b0000) begin errors++; $display("FAIL midrst_wr_en: got %b expected 0000", wr_en); end
    checks++; if (gnt !== 2'b00)     begin errors++; $display("FAIL midrst_gnt: got %b expected 00", gnt); end
    nclr = 1'b1; req = 2'b00;
    tick();
    checks++; if (regs[0] !== 8'h00) begin errors++; $display("FAIL midrst_reg0: got %h expected 00", regs[0]); end
  endtask

  task automatic test_out_of_range();
    do_reset();
    req = 2'b01; addr = {2'd0, 2'd3}; data = {8'h00, 8'h77};
    tick();
    checks++; if (gnt3 !== 2'b01)    begin errors++; $display("FAIL oor_gnt: got %b expected 01", gnt3); end
    checks++; if (wr_en3 !== 3'b000) begin errors++; $display("FAIL oor_wr_en: got %b expected 000", wr_en3); end
    checks++; if (wr_en !== 4'b1000) begin errors++; $display("FAIL oor_inrange_wr_en: got %b expected 1000", wr_en); end
    req = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_back_to_back();
    test_hold();
    test_reset_mid_write();
    test_out_of_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded 50000 time units");
    $fatal(1);
  end
endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
Shares the single write path into a bank of NREGS 8-bit `register` instances between NREQ requesters, e.g. ALU writeback and memory load. It picks one requester per cycle using round-robin priority and returns a one-cycle grant. It drives a one-hot enable bus, wired to each register's `en`, plus a shared data bus, wired to every register's `d`. All outputs are registered, so the register bank sees clean, glitch-free enables.

Parameters:
NREQ, 2, number of requesters (2..4)
NREGS, 4, number of registers in the bank
AW, 2, register address width; NREGS <= 2**AW
WIDTH, 8, data width

Ports:
clk  in  1  system clock; all state updates on rising edge
nclr  in  1  asynchronous active-low reset, same polarity as the `register` nclr
req  in  NREQ  per-requester write request, level, bit i = requester i
addr  in  NREQ*AW  flattened target addresses; requester i uses bits [i*AW +: AW]
data  in  NREQ*WIDTH  flattened write data; requester i uses bits [i*WIDTH +: WIDTH]
hold  in  1  stall: blocks new grants while high
gnt  out  NREQ  one-hot grant, high for exactly one cycle
wr_en  out  NREGS  one-hot register enable, drives `register.en`
wr_data  out  WIDTH  write data, drives `register.d`
busy  out  1  high while any req bit is high and not being granted this cycle

Behaviour:
- Reset (nclr=0), asynchronous and immediate:
  - gnt=0, wr_en=0, wr_data=0, busy=0.
  - Priority pointer ptr=0.
  - Reset mid-grant cancels the write; no register update occurs.
- Eligibility:
  - Requester i is eligible in cycle N if req[i]=1 and gnt[i]=0 in cycle N.
  - This prevents a double grant while the requester is still dropping req.
- Arbitration, evaluated combinationally in cycle N and registered at the rising edge ending cycle N:
  - If hold=0 and any requester is eligible, the winner is the first eligible index found scanning ptr, ptr+1, ... modulo NREQ.
  - At the edge: gnt <= onehot(winner); wr_en <= onehot(addr[winner]); wr_data <= data[winner]; ptr <= (winner+1) mod NREQ.
  - Otherwise: gnt <= 0, wr_en <= 0, ptr is unchanged, wr_data holds its last value.
- Latency and handshake:
  - A request sampled at edge E produces gnt and wr_en high during the cycle after E.
  - The register captures wr_data at the next edge, E+1.
  - The requester holds req/addr/data stable until it sees gnt=1, then deasserts req before edge E+2 if it has no further write.
  - If req stays high, the requester is treated as a new request, eligible again from cycle E+2.
- Address range: if addr[winner] >= NREGS, the grant is still issued but wr_en=0, so the write is dropped silently.
- hold:
  - hold=1 at an edge forces gnt=0 and wr_en=0 for the following cycle.
  - Pending requests wait and ptr is not advanced.
- Simultaneous requests to the same address: serialised by round-robin; the later grant wins the final value.
- Fairness: with all NREQ requesters continuously requesting, each is granted at least once every NREQ+1 cycles.
- busy = |(req & ~gnt) after registering, i.e. busy is a registered output, updated every edge.
- One-hot invariants: gnt has at most 1 bit set; wr_en has at most 1 bit set.

Test Plan:
- nclr=0 for #100 with req=2'b11 → gnt=0, wr_en=0, wr_data=0, busy=0; release nclr and apply 2 clocks → first grant goes to requester 0 (ptr=0).
- Single request: req0=1, addr0=2, data0=8'h12 → after 1 edge gnt=2'b01, wr_en=4'b0100, wr_data=8'h12; register 2 reads 8'h12 after the next edge and registers 0, 1, 3 stay 8'h00.
- Contention: req=2'b11, addr0=1/data0=8'h34, addr1=1/data1=8'h56, held until each is granted → grants are 01 then 10 on consecutive-eligible cycles, and register 1 ends at 8'h56.
- Fairness: both requesters hold req=1 for 8 cycles → grants alternate 01, 10, ...; requester 0 never gets back-to-back grants.
- hold=1 with req0 pending for 3 cycles → gnt=0 and wr_en=0 throughout; on hold=0, grant appears after 1 edge with ptr unchanged.
- Reset mid-write: gnt high and nclr pulsed low before the capture edge → wr_en drops immediately and the target register keeps its old value (8'h00); out-of-range addr=3 with NREGS=3 → gnt=1, wr_en=0.
